fsincos_issue_arb: RTL and testbench



---
 rtl/fsincos_issue_arb_if.sv | 58 +++++
 rtl/fsincos_issue_arb.sv | 132 +++++++++++++
 tb/tb_fsincos_issue_arb.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fsincos_issue_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fsincos_issue_arb_if                                             |
// | Brief   : Requester, pipeline and response bundle for fsincos_issue_arb.   |
// |           slave = arbiter side, master = requester/pipeline environment.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface fsincos_issue_arb_if #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int RSP_DEPTH  = 8
);
  localparam int c_W  = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int c_CW = $clog2(RSP_DEPTH) + 1;

  logic            i_req0_valid;
  logic            o_req0_ready;
  logic [c_W-1:0]  i_req0_operand;
  logic            i_req0_proced;
  logic            i_req1_valid;
  logic            o_req1_ready;
  logic [c_W-1:0]  i_req1_operand;
  logic            i_req1_proced;
  logic            o_pipe_valid;
  logic [c_W-1:0]  o_pipe_operand;
  logic            o_pipe_proced;
  logic            i_pipe_valid;
  logic [c_W-1:0]  i_pipe_result;
  logic            o_rsp_valid;
  logic            i_rsp_ready;
  logic            o_rsp_id;
  logic [c_W-1:0]  o_rsp_result;
  logic [c_CW-1:0] o_inflight;
  logic            o_err_underflow;
  logic [15:0]     o_gnt_cnt0;
  logic [15:0]     o_gnt_cnt1;

  modport slave (
    input  i_req0_valid, i_req0_operand, i_req0_proced,
    input  i_req1_valid, i_req1_operand, i_req1_proced,
    input  i_pipe_valid, i_pipe_result, i_rsp_ready,
    output o_req0_ready, o_req1_ready,
    output o_pipe_valid, o_pipe_operand, o_pipe_proced,
    output o_rsp_valid, o_rsp_id, o_rsp_result,
    output o_inflight, o_err_underflow, o_gnt_cnt0, o_gnt_cnt1
  );

  modport master (
    output i_req0_valid, i_req0_operand, i_req0_proced,
    output i_req1_valid, i_req1_operand, i_req1_proced,
    output i_pipe_valid, i_pipe_result, i_rsp_ready,
    input  o_req0_ready, o_req1_ready,
    input  o_pipe_valid, o_pipe_operand, o_pipe_proced,
    input  o_rsp_valid, o_rsp_id, o_rsp_result,
    input  o_inflight, o_err_underflow, o_gnt_cnt0, o_gnt_cnt1
  );
endinterface
`default_nettype wire

// File: rtl/fsincos_issue_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fsincos_issue_arb                                                |
// | Brief   : Two-port round-robin issue arbiter for the fsincos pipeline with |
// |           in-order tag tracking and a credit-protected response FIFO.      |
// |           Optional grant counters: define FSINCOS_ARB_GNT_CNT_EN.          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fsincos_issue_arb #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int RSP_DEPTH  = 8
) (
  input  wire logic          i_clk,
  input  wire logic          i_rst,
  fsincos_issue_arb_if.slave bus
);
  localparam int c_W  = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int c_AW = $clog2(RSP_DEPTH);
  localparam int c_CW = c_AW + 1;

  logic                 r_prio;
  logic [RSP_DEPTH-1:0] r_tag_mem;
  logic [c_AW-1:0]      r_tag_wr;
  logic [c_AW-1:0]      r_tag_rd;
  logic [c_CW-1:0]      r_inflight;
  logic [c_W:0]         r_rsp_mem [RSP_DEPTH];
  logic [c_AW-1:0]      r_rsp_wr;
  logic [c_AW-1:0]      r_rsp_rd;
  logic [c_CW-1:0]      r_rsp_cnt;
  logic                 r_pipe_valid;
  logic [c_W-1:0]       r_pipe_operand;
  logic                 r_pipe_proced;
  logic                 r_err;

  logic [c_CW:0]        w_used;
  logic                 w_credit_ok;
  logic                 w_gnt0;
  logic                 w_gnt1;
  logic                 w_acc;
  logic                 w_ret;
  logic                 w_unf;
  logic                 w_rsp_valid;
  logic                 w_rsp_pop;
  logic [c_W:0]         w_rsp_head;

  // Credits cover both in-flight ops and queued responses, so the pipeline never overruns the FIFO.
  assign w_used      = {1'b0, r_inflight} + {1'b0, r_rsp_cnt};
  assign w_credit_ok = w_used < (c_CW+1)'(RSP_DEPTH);
  assign w_gnt0      = bus.i_req0_valid & (~bus.i_req1_valid | ~r_prio);
  assign w_gnt1      = bus.i_req1_valid & (~bus.i_req0_valid |  r_prio);
  assign w_acc       = w_credit_ok & (w_gnt0 | w_gnt1);
  assign w_ret       = bus.i_pipe_valid & (r_inflight != '0);
  assign w_unf       = bus.i_pipe_valid & (r_inflight == '0);
  assign w_rsp_valid = r_rsp_cnt != '0;
  assign w_rsp_pop   = w_rsp_valid & bus.i_rsp_ready;
  assign w_rsp_head  = r_rsp_mem[r_rsp_rd];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prio         <= 1'b0;
      r_tag_mem      <= '0;
      r_tag_wr       <= '0;
      r_tag_rd       <= '0;
      r_inflight     <= '0;
      r_rsp_wr       <= '0;
      r_rsp_rd       <= '0;
      r_rsp_cnt      <= '0;
      r_pipe_valid   <= 1'b0;
      r_pipe_operand <= '0;
      r_pipe_proced  <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_pipe_valid <= w_acc;
      if (w_acc) begin
        r_pipe_operand      <= w_gnt1 ? bus.i_req1_operand : bus.i_req0_operand;
        r_pipe_proced       <= w_gnt1 ? bus.i_req1_proced  : bus.i_req0_proced;
        r_prio              <= ~w_gnt1;
        r_tag_mem[r_tag_wr] <= w_gnt1;
        r_tag_wr            <= r_tag_wr + 1'b1;
      end
      if (w_ret) begin
        r_tag_rd <= r_tag_rd + 1'b1;
        r_rsp_wr <= r_rsp_wr + 1'b1;
      end
      if (w_acc && !w_ret) r_inflight <= r_inflight + 1'b1;
      else if (!w_acc && w_ret) r_inflight <= r_inflight - 1'b1;
      if (w_rsp_pop) r_rsp_rd <= r_rsp_rd + 1'b1;
      if (w_ret && !w_rsp_pop) r_rsp_cnt <= r_rsp_cnt + 1'b1;
      else if (!w_ret && w_rsp_pop) r_rsp_cnt <= r_rsp_cnt - 1'b1;
      if (w_unf) r_err <= 1'b1;
    end
  end

  // Response storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (w_ret && !i_rst) r_rsp_mem[r_rsp_wr] <= {r_tag_mem[r_tag_rd], bus.i_pipe_result};
  end

`ifdef FSINCOS_ARB_GNT_CNT_EN
  logic [15:0] r_gnt_cnt0;
  logic [15:0] r_gnt_cnt1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gnt_cnt0 <= '0;
      r_gnt_cnt1 <= '0;
    end else begin
      if (w_acc && !w_gnt1 && r_gnt_cnt0 != 16'hFFFF) r_gnt_cnt0 <= r_gnt_cnt0 + 1'b1;
      if (w_acc &&  w_gnt1 && r_gnt_cnt1 != 16'hFFFF) r_gnt_cnt1 <= r_gnt_cnt1 + 1'b1;
    end
  end

  assign bus.o_gnt_cnt0 = r_gnt_cnt0;
  assign bus.o_gnt_cnt1 = r_gnt_cnt1;
`else
  assign bus.o_gnt_cnt0 = '0;
  assign bus.o_gnt_cnt1 = '0;
`endif

  assign bus.o_req0_ready    = w_credit_ok & w_gnt0;
  assign bus.o_req1_ready    = w_credit_ok & w_gnt1;
  assign bus.o_pipe_valid    = r_pipe_valid;
  assign bus.o_pipe_operand  = r_pipe_operand;
  assign bus.o_pipe_proced   = r_pipe_proced;
  assign bus.o_rsp_valid     = w_rsp_valid;
  assign bus.o_rsp_id        = w_rsp_valid & w_rsp_head[c_W];
  assign bus.o_rsp_result    = w_rsp_valid ? w_rsp_head[c_W-1:0] : '0;
  assign bus.o_inflight      = r_inflight;
  assign bus.o_err_underflow = r_err;
endmodule
`default_nettype wire

// File: tb/tb_fsincos_issue_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fsincos_issue_arb                                             |
// | Brief   : Random-stimulus bench for fsincos_issue_arb with a queue model.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fsincos_issue_arb;
  localparam int c_DEPTH = 8;
  localparam int c_LAT   = 6;
  localparam int c_W     = 32;
`ifdef FSINCOS_ARB_GNT_CNT_EN
  localparam bit c_CNT_EN = 1'b1;
`else
  localparam bit c_CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fsincos_issue_arb_if #(.EXP_WIDTH(8), .FRAC_WIDTH(23), .RSP_DEPTH(c_DEPTH)) bus ();

  fsincos_issue_arb #(.EXP_WIDTH(8), .FRAC_WIDTH(23), .RSP_DEPTH(c_DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {int at; logic [c_W-1:0] res;} ret_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: plain queues of in-flight owners and pending responses.
  int             m_prio = 0;
  int             m_inf_q[$];
  logic [c_W:0]   m_rsp_q[$];
  bit             m_iv = 0;
  logic [c_W-1:0] m_iop = '0;
  bit             m_ipr = 0;
  bit             m_err = 0;
  int             m_cnt0 = 0;
  int             m_cnt1 = 0;
  ret_t           ret_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [c_W-1:0] pipe_fn(input logic [c_W-1:0] op, input bit pr);
    return {~op[c_W-1], op[c_W-2:0]} ^ c_W'(pr);
  endfunction

  // mode: 0 both valid/drain, 1 req1 only, 2 both valid/no drain, 3 random, 4 idle/drain
  task automatic cycle(input bit r, input int mode, input bit spur);
    bit v0, v1, rr, ret, cred, acc;
    logic [c_W-1:0] op0, op1, rres;
    bit pr0, pr1;
    int g, id;
    logic [c_W:0] head;
    case (mode)
      0:       begin v0 = 1; v1 = 1; rr = 1; end
      1:       begin v0 = 0; v1 = 1; rr = 1; end
      2:       begin v0 = 1; v1 = 1; rr = 0; end
      3:       begin v0 = ($urandom_range(0, 3) != 0); v1 = ($urandom_range(0, 3) != 0);
                     rr = ($urandom_range(0, 2) != 0); end
      default: begin v0 = 0; v1 = 0; rr = 1; end
    endcase
    op0 = $urandom; op1 = $urandom;
    pr0 = 1'($urandom_range(0, 1)); pr1 = 1'($urandom_range(0, 1));
    ret = 0; rres = $urandom;
    if (ret_q.size() > 0 && ret_q[0].at == cyc) begin
      ret = 1; rres = ret_q[0].res; void'(ret_q.pop_front());
    end
    ret = ret | spur;
    rst = r;
    bus.i_req0_valid = v0; bus.i_req0_operand = op0; bus.i_req0_proced = pr0;
    bus.i_req1_valid = v1; bus.i_req1_operand = op1; bus.i_req1_proced = pr1;
    bus.i_pipe_valid = ret; bus.i_pipe_result = rres; bus.i_rsp_ready = rr;

    @(negedge clk);
    cred = (m_inf_q.size() + m_rsp_q.size()) < c_DEPTH;
    g = -1;
    if (v0 && v1) g = m_prio;
    else if (v0) g = 0;
    else if (v1) g = 1;
    head = (m_rsp_q.size() > 0) ? m_rsp_q[0] : '0;
    chk("req0_ready", 64'(bus.o_req0_ready), 64'(cred && g == 0));
    chk("req1_ready", 64'(bus.o_req1_ready), 64'(cred && g == 1));
    chk("pipe_valid", 64'(bus.o_pipe_valid), 64'(m_iv));
    if (m_iv) begin
      chk("pipe_operand", 64'(bus.o_pipe_operand), 64'(m_iop));
      chk("pipe_proced", 64'(bus.o_pipe_proced), 64'(m_ipr));
    end
    chk("rsp_valid", 64'(bus.o_rsp_valid), 64'(m_rsp_q.size() > 0));
    chk("rsp_id", 64'(bus.o_rsp_id), 64'(head[c_W]));
    chk("rsp_result", 64'(bus.o_rsp_result), 64'(head[c_W-1:0]));
    chk("inflight", 64'(bus.o_inflight), 64'(m_inf_q.size()));
    chk("err_underflow", 64'(bus.o_err_underflow), 64'(m_err));
    chk("gnt_cnt0", 64'(bus.o_gnt_cnt0), c_CNT_EN ? 64'(m_cnt0) : 64'd0);
    chk("gnt_cnt1", 64'(bus.o_gnt_cnt1), c_CNT_EN ? 64'(m_cnt1) : 64'd0);

    // The pipeline keeps running through reset; issued ops still come back.
    if (m_iv) ret_q.push_back('{cyc + 1 + c_LAT, pipe_fn(m_iop, m_ipr)});
    if (r) begin
      m_prio = 0; m_inf_q.delete(); m_rsp_q.delete();
      m_iv = 0; m_iop = '0; m_ipr = 0; m_err = 0; m_cnt0 = 0; m_cnt1 = 0;
    end else begin
      acc = cred && (g >= 0);
      if (m_rsp_q.size() > 0 && rr) void'(m_rsp_q.pop_front());
      if (ret) begin
        if (m_inf_q.size() == 0) m_err = 1;
        else begin
          id = m_inf_q.pop_front();
          chk("rsp_no_overflow", 64'(m_rsp_q.size() < c_DEPTH), 64'd1);
          m_rsp_q.push_back({1'(id), rres});
        end
      end
      m_iv = acc;
      if (acc) begin
        m_iop = (g == 1) ? op1 : op0;
        m_ipr = (g == 1) ? pr1 : pr0;
        m_inf_q.push_back(g);
        m_prio = 1 - g;
        if (g == 0 && m_cnt0 < 16'hFFFF) m_cnt0++;
        if (g == 1 && m_cnt1 < 16'hFFFF) m_cnt1++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    bus.i_req0_valid = 0; bus.i_req0_operand = '0; bus.i_req0_proced = 0;
    bus.i_req1_valid = 0; bus.i_req1_operand = '0; bus.i_req1_proced = 0;
    bus.i_pipe_valid = 0; bus.i_pipe_result = '0; bus.i_rsp_ready = 0;
    @(posedge clk);
    #1;
    repeat (2) cycle(1, 4, 0);
    repeat (30) cycle(0, 0, 0);
    repeat (14) cycle(0, 4, 0);
    repeat (4) cycle(0, 1, 0);
    repeat (4) cycle(0, 0, 0);
    repeat (14) cycle(0, 4, 0);
    repeat (20) cycle(0, 2, 0);
    cycle(0, 0, 0);
    repeat (5) cycle(0, 2, 0);
    repeat (20) cycle(0, 4, 0);
    repeat (300) cycle(0, 3, 0);
    repeat (10) cycle(0, 0, 0);
    cycle(1, 0, 0);
    repeat (12) cycle(0, 4, 0);
    cycle(1, 4, 0);
    cycle(0, 4, 1);
    repeat (6) cycle(0, 4, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
